// File: rtl/exmem_stage.sv
// -----------------------------------------------------------------------------
// exmem_stage
//   EX/MEM pipeline stage. Latches the executed instruction, performs the
//   data-memory access over a REQ/ACK handshake with a bounded wait, stalls
//   upstream while the access is outstanding, and presents the completed
//   instruction (ALU result or load data) to MEM/WB.
//   All state updates on the falling edge of CLK; RST is asynchronous,
//   active high.
//
// Ports
//   CLK, RST                  clock (falling-edge active), async reset
//   IN_VALID, FLUSH           incoming instruction qualifier / squash
//   ALU_RESULT, ST_DATA       EX result (also byte address), store data
//   WA, BE, MEM_RD, MEM_WR    destination reg, byte enables, load/store
//   RWSrc, RF_WE              write-back source select, RF write enable
//   D_MEM_ACK, D_MEM_DI       memory completion and read data
//   STALL                     freeze upstream while an access is pending
//   D_MEM_REQ/ADDR/WE/BE/DOUT memory request side
//   OUT_VALID                 completed instruction strobe to MEM/WB
//   ALU_RESULT_OUT, LD_DATA_OUT, WA_OUT, RWSrc_OUT, RF_WE_OUT
//                             latched write-back payload
//   MEM_ERR                   sticky memory timeout flag
// -----------------------------------------------------------------------------
module exmem_stage #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic              FLUSH,
  input  logic [31:0]       ALU_RESULT,
  input  logic [31:0]       ST_DATA,
  input  logic [4:0]        WA,
  input  logic [3:0]        BE,
  input  logic              MEM_RD,
  input  logic              MEM_WR,
  input  logic [1:0]        RWSrc,
  input  logic              RF_WE,
  input  logic              D_MEM_ACK,
  input  logic [31:0]       D_MEM_DI,
  output logic              STALL,
  output logic              D_MEM_REQ,
  output logic [ADDR_W-1:0] D_MEM_ADDR,
  output logic              D_MEM_WE,
  output logic [3:0]        D_MEM_BE,
  output logic [31:0]       D_MEM_DOUT,
  output logic              OUT_VALID,
  output logic [31:0]       ALU_RESULT_OUT,
  output logic [31:0]       LD_DATA_OUT,
  output logic [4:0]        WA_OUT,
  output logic [1:0]        RWSrc_OUT,
  output logic              RF_WE_OUT,
  output logic              MEM_ERR
);

  localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  // Counter value seen on the WAIT_LIMIT-th ACCESS edge (counts prior waits)
  localparam int unsigned LAST  = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        st_q, st_d;
  logic [4:0]         wa_q, wa_d;
  logic [3:0]         be_q, be_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [1:0]         rws_q, rws_d;
  logic               rfwe_q, rfwe_d;
  logic               out_valid_q, out_valid_d;
  logic               rf_we_out_q, rf_we_out_d;
  logic [31:0]        ld_q, ld_d;
  logic               err_q, err_d;

  // State and payload registers
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_q       <= '0;
      st_q        <= '0;
      wa_q        <= '0;
      be_q        <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rws_q       <= '0;
      rfwe_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rf_we_out_q <= 1'b0;
      ld_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_q       <= alu_d;
      st_q        <= st_d;
      wa_q        <= wa_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rws_q       <= rws_d;
      rfwe_q      <= rfwe_d;
      out_valid_q <= out_valid_d;
      rf_we_out_q <= rf_we_out_d;
      ld_q        <= ld_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_d       = alu_q;
    st_d        = st_q;
    wa_d        = wa_q;
    be_d        = be_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rws_d       = rws_q;
    rfwe_d      = rfwe_q;
    out_valid_d = 1'b0;
    rf_we_out_d = 1'b0;
    ld_d        = ld_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID && !FLUSH) begin
          alu_d  = ALU_RESULT;
          st_d   = ST_DATA;
          wa_d   = WA;
          be_d   = BE;
          rd_d   = MEM_RD;
          wr_d   = MEM_WR;
          rws_d  = RWSrc;
          rfwe_d = RF_WE;
          if (MEM_RD || MEM_WR) begin
            state_d = ACCESS;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            rf_we_out_d = RF_WE;
          end
        end
      end

      ACCESS: begin
        if (D_MEM_ACK) begin
          // RD+WR together behaves as a store: no capture, no RF write
          if (rd_q && !wr_q) begin
            ld_d = D_MEM_DI;
          end
          out_valid_d = 1'b1;
          rf_we_out_d = rfwe_q && !(rd_q && wr_q);
          state_d     = IDLE;
        end else if ((WAIT_LIMIT > 0) && (cnt_q == CNT_W'(LAST))) begin
          err_d       = 1'b1;
          ld_d        = '0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (WAIT_LIMIT > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory side is decoded straight from the state and latched fields
  assign STALL          = (state_q == ACCESS);
  assign D_MEM_REQ      = (state_q == ACCESS);
  assign D_MEM_WE       = (state_q == ACCESS) && wr_q;
  assign D_MEM_ADDR     = alu_q[ADDR_W-1:0];
  assign D_MEM_BE       = be_q;
  assign D_MEM_DOUT     = st_q;

  assign OUT_VALID      = out_valid_q;
  assign ALU_RESULT_OUT = alu_q;
  assign LD_DATA_OUT    = ld_q;
  assign WA_OUT         = wa_q;
  assign RWSrc_OUT      = rws_q;
  assign RF_WE_OUT      = rf_we_out_q;
  assign MEM_ERR        = err_q;

endmodule

// File: tb/tb_exmem_stage.sv
// -----------------------------------------------------------------------------
// tb_exmem_stage
//   Directed stimulus with a scoreboard: the driver pushes expected memory
//   requests and expected completions; a monitor on the rising edge (away
//   from the falling active edge) pops and compares them.
// -----------------------------------------------------------------------------
module tb_exmem_stage;

  localparam int unsigned WL = 4;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        FLUSH;
  logic [31:0] ALU_RESULT;
  logic [31:0] ST_DATA;
  logic [4:0]  WA;
  logic [3:0]  BE;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [1:0]  RWSrc;
  logic        RF_WE;
  logic        D_MEM_ACK;
  logic [31:0] D_MEM_DI;
  logic        STALL;
  logic        D_MEM_REQ;
  logic [11:0] D_MEM_ADDR;
  logic        D_MEM_WE;
  logic [3:0]  D_MEM_BE;
  logic [31:0] D_MEM_DOUT;
  logic        OUT_VALID;
  logic [31:0] ALU_RESULT_OUT;
  logic [31:0] LD_DATA_OUT;
  logic [4:0]  WA_OUT;
  logic [1:0]  RWSrc_OUT;
  logic        RF_WE_OUT;
  logic        MEM_ERR;

  exmem_stage #(.ADDR_W(12), .WAIT_LIMIT(WL)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
    .ALU_RESULT(ALU_RESULT), .ST_DATA(ST_DATA), .WA(WA), .BE(BE),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .RWSrc(RWSrc), .RF_WE(RF_WE),
    .D_MEM_ACK(D_MEM_ACK), .D_MEM_DI(D_MEM_DI), .STALL(STALL),
    .D_MEM_REQ(D_MEM_REQ), .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WE(D_MEM_WE),
    .D_MEM_BE(D_MEM_BE), .D_MEM_DOUT(D_MEM_DOUT), .OUT_VALID(OUT_VALID),
    .ALU_RESULT_OUT(ALU_RESULT_OUT), .LD_DATA_OUT(LD_DATA_OUT),
    .WA_OUT(WA_OUT), .RWSrc_OUT(RWSrc_OUT), .RF_WE_OUT(RF_WE_OUT),
    .MEM_ERR(MEM_ERR)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic        chk_ld;
    logic [4:0]  wa;
    logic [1:0]  rws;
    logic        rfwe;
    logic        err;
  } cmp_t;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dout;
    int          len;
  } req_t;

  cmp_t cq[$];
  req_t rq[$];
  int   vectors = 0;
  int   errors  = 0;
  logic exp_err = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: request side and completion side
  logic prev_req = 1'b0;
  logic in_req   = 1'b0;
  int   req_len  = 0;
  req_t cur;

  always @(posedge CLK) begin
    if (RST) begin
      in_req   = 1'b0;
      prev_req = 1'b0;
    end else begin
      check("stall_eq_req", 32'(STALL), 32'(D_MEM_REQ));
      if (!D_MEM_REQ) check("we_idle", 32'(D_MEM_WE), 32'd0);

      if (D_MEM_REQ) begin
        if (!in_req) begin
          if (rq.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_req: got REQ=1 expected REQ=0 at %0t", $time);
          end else begin
            cur     = rq.pop_front();
            in_req  = 1'b1;
            req_len = 0;
          end
        end
        if (in_req) begin
          req_len++;
          check("req_addr", 32'(D_MEM_ADDR), 32'(cur.addr));
          check("req_we",   32'(D_MEM_WE),   32'(cur.we));
          check("req_be",   32'(D_MEM_BE),   32'(cur.be));
          check("req_dout", D_MEM_DOUT,      cur.dout);
        end
      end else if (in_req) begin
        check("req_len", 32'(req_len), 32'(cur.len));
        in_req = 1'b0;
      end
      prev_req = D_MEM_REQ;

      if (OUT_VALID) begin
        if (cq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_out: got OUT_VALID=1 expected OUT_VALID=0 at %0t", $time);
        end else begin
          cmp_t e;
          e = cq.pop_front();
          check("alu_out", ALU_RESULT_OUT, e.alu);
          check("wa_out",  32'(WA_OUT),    32'(e.wa));
          check("rws_out", 32'(RWSrc_OUT), 32'(e.rws));
          check("rf_we",   32'(RF_WE_OUT), 32'(e.rfwe));
          check("mem_err", 32'(MEM_ERR),   32'(e.err));
          if (e.chk_ld) check("ld_data", LD_DATA_OUT, e.ld);
        end
      end else begin
        check("rf_we_idle", 32'(RF_WE_OUT), 32'd0);
      end
    end
  end

  // Issue one instruction; ack_at = ACCESS edge carrying ACK (0 = never),
  // flush_k = ACCESS edge on which FLUSH/IN_VALID are pulsed (0 = none)
  task automatic issue(input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] wa, input logic [3:0] be,
                       input logic rd, input logic wr, input logic [1:0] rws,
                       input logic rfwe, input int ack_at, input logic [31:0] di,
                       input int flush_k);
    cmp_t e;
    req_t r;
    int   n;
    logic aborted;
    @(posedge CLK);
    IN_VALID   = 1'b1;
    FLUSH      = 1'b0;
    ALU_RESULT = alu;
    ST_DATA    = st;
    WA         = wa;
    BE         = be;
    MEM_RD     = rd;
    MEM_WR     = wr;
    RWSrc      = rws;
    RF_WE      = rfwe;
    D_MEM_ACK  = 1'b0;
    aborted    = (rd || wr) && !(ack_at > 0 && ack_at <= int'(WL));
    n          = (ack_at > 0 && ack_at <= int'(WL)) ? ack_at : int'(WL);
    if (aborted) exp_err = 1'b1;
    e.alu    = alu;
    e.wa     = wa;
    e.rws    = rws;
    e.err    = exp_err;
    e.ld     = aborted ? 32'd0 : di;
    e.chk_ld = aborted || (rd && !wr);
    e.rfwe   = rfwe && !aborted && !(rd && wr);
    cq.push_back(e);
    if (rd || wr) begin
      r.addr = alu[11:0];
      r.we   = wr;
      r.be   = be;
      r.dout = st;
      r.len  = n;
      rq.push_back(r);
    end
    @(negedge CLK);
    if (rd || wr) begin
      for (int k = 1; k <= n; k++) begin
        @(posedge CLK);
        IN_VALID   = (k == flush_k);
        FLUSH      = (k == flush_k);
        ALU_RESULT = (k == flush_k) ? 32'hFFFF_FFFF : alu;
        D_MEM_ACK  = (k == ack_at);
        D_MEM_DI   = (k == ack_at) ? di : 32'h0BAD_F00D;
        @(negedge CLK);
      end
    end
  endtask

  task automatic idle(input logic ack, input logic flush_valid);
    @(posedge CLK);
    IN_VALID  = flush_valid;
    FLUSH     = flush_valid;
    RF_WE     = 1'b1;
    MEM_RD    = 1'b0;
    MEM_WR    = 1'b0;
    D_MEM_ACK = ack;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; ALU_RESULT = '0; ST_DATA = '0;
    WA = '0; BE = '0; MEM_RD = 1'b0; MEM_WR = 1'b0; RWSrc = '0; RF_WE = 1'b0;
    D_MEM_ACK = 1'b0; D_MEM_DI = '0;
    #1;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_stall",     32'(STALL),     32'd0);
    check("rst_req",       32'(D_MEM_REQ), 32'd0);
    check("rst_err",       32'(MEM_ERR),   32'd0);
    check("rst_alu",       ALU_RESULT_OUT, 32'd0);
    check("rst_ld",        LD_DATA_OUT,    32'd0);
    @(posedge CLK); #2 RST = 1'b0;

    // ALU pass-through, then a second one back to back
    issue(32'h0000_1234, 32'h0, 5'd5, 4'hF, 1'b0, 1'b0, 2'd1, 1'b1, 0, 32'h0, 0);
    issue(32'h8000_0001, 32'h0, 5'd31, 4'hF, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 0);
    // Load, ACK on 3rd ACCESS edge
    issue(32'h0000_0104, 32'h0, 5'd7, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 3, 32'hDEAD_BEEF, 0);
    // Store, immediate ACK
    issue(32'h0000_0208, 32'hA5A5_5A5A, 5'd0, 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0, 1, 32'h0, 0);
    // Flush in IDLE, and ACK in IDLE ignored
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b0);
    // Load with FLUSH pulsed during ACCESS
    issue(32'h0000_0F10, 32'h0, 5'd9, 4'hF, 1'b1, 1'b0, 2'd3, 1'b1, 2, 32'h1357_9BDF, 1);
    // ACK on the abort edge completes normally
    issue(32'h0000_0ABC, 32'h0, 5'd11, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 4, 32'hCAFE_F00D, 0);
    // RD+WR treated as store, RF write suppressed
    issue(32'h0000_0333, 32'h1122_3344, 5'd12, 4'b1100, 1'b1, 1'b1, 2'd0, 1'b1, 2, 32'h5555_AAAA, 0);
    // Timeout, then MEM_ERR stays set
    issue(32'h0000_0440, 32'h0, 5'd13, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 0, 32'h0, 0);
    issue(32'h0000_0055, 32'h0, 5'd14, 4'hF, 1'b0, 1'b0, 2'd1, 1'b1, 0, 32'h0, 0);
    issue(32'h0000_0560, 32'h0, 5'd15, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 1, 32'h2468_ACE0, 0);

    // Reset in the middle of a load
    @(posedge CLK);
    IN_VALID = 1'b1; FLUSH = 1'b0; ALU_RESULT = 32'h0000_0200; MEM_RD = 1'b1;
    MEM_WR = 1'b0; BE = 4'hF; RF_WE = 1'b1; D_MEM_ACK = 1'b0;
    begin
      req_t r;
      r.addr = 12'h200; r.we = 1'b0; r.be = 4'hF; r.dout = ST_DATA; r.len = 0;
      rq.push_back(r);
    end
    @(negedge CLK);
    @(posedge CLK); IN_VALID = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #2 RST = 1'b1;
    #1;
    exp_err = 1'b0;
    check("mid_rst_req",   32'(D_MEM_REQ), 32'd0);
    check("mid_rst_stall", 32'(STALL),     32'd0);
    check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_err",   32'(MEM_ERR),   32'd0);
    @(negedge CLK);
    @(posedge CLK); #2 RST = 1'b0;
    issue(32'h0000_0777, 32'h0, 5'd3, 4'hF, 1'b0, 1'b0, 2'd1, 1'b1, 0, 32'h0, 0);

    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(posedge CLK); #1;
    check("cq_drained", 32'(cq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the ID/EX pipeline register.
- Latches the executed instruction (ALU result, store data, destination register, memory and write-back controls) and runs the data-memory access over a request/acknowledge handshake with bounded wait.
- Stalls upstream while an access is outstanding.
- Presents a completed instruction (ALU result or load data) to the MEM/WB stage.

Parameters:
ADDR_W, 12, width of D_MEM_ADDR; taken from ALU_RESULT[ADDR_W-1:0]
WAIT_LIMIT, 15, max falling edges a request is held without ACK before abort; 0 = no timeout

Ports:
CLK  in  1  clock; all state updates on falling edge, same as other pipeline registers
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  instruction present at ID/EX output
FLUSH  in  1  squash the incoming instruction
ALU_RESULT  in  32  EX result / memory byte address
ST_DATA  in  32  store data (RF_RD2 path after forwarding)
WA  in  5  destination register
BE  in  4  byte enables
MEM_RD  in  1  load
MEM_WR  in  1  store
RWSrc  in  2  write-back source select
RF_WE  in  1  register-file write enable
D_MEM_ACK  in  1  memory completion
D_MEM_DI  in  32  memory read data, valid with ACK
STALL  out  1  freeze upstream; equals (state==ACCESS)
D_MEM_REQ  out  1  access request
D_MEM_ADDR  out  ADDR_W  access address
D_MEM_WE  out  1  1 = write
D_MEM_BE  out  4  byte enables
D_MEM_DOUT  out  32  write data
OUT_VALID  out  1  completed instruction presented to MEM/WB
ALU_RESULT_OUT  out  32  latched ALU result
LD_DATA_OUT  out  32  captured load data
WA_OUT  out  5  destination register
RWSrc_OUT  out  2  write-back select
RF_WE_OUT  out  1  latched RF_WE AND OUT_VALID AND not aborted
MEM_ERR  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous: every output and register is 0, FSM in IDLE, wait counter 0, MEM_ERR 0. Reset mid-ACCESS drops D_MEM_REQ and STALL immediately; the access is abandoned.
- FSM states: IDLE, ACCESS.
- IDLE, falling edge, IN_VALID=1 and FLUSH=0:
  - Latch all input fields.
  - If MEM_RD or MEM_WR: go to ACCESS, OUT_VALID<=0, counter<=0.
  - Otherwise: stay in IDLE, OUT_VALID<=1. Pass-through latency is 1 edge.
- IDLE, falling edge, IN_VALID=0 or FLUSH=1: OUT_VALID<=0; latched fields are don't-care; RF_WE_OUT is 0.
- ACCESS outputs:
  - D_MEM_REQ=1; STALL=1.
  - D_MEM_ADDR, D_MEM_WE=MEM_WR, D_MEM_BE and D_MEM_DOUT are driven from the latched fields and stay stable until exit.
- ACCESS, edge with D_MEM_ACK=1:
  - If the instruction is a load, LD_DATA_OUT<=D_MEM_DI.
  - OUT_VALID<=1; go to IDLE. STALL falls after that edge.
  - Upstream advances one edge later.
  - Minimum memory-op latency is 2 edges: entry, then ACK at the first ACCESS edge.
- ACCESS, edge without ACK: counter increments.
  - If WAIT_LIMIT>0 and this is the WAIT_LIMIT-th ACCESS edge, abort: MEM_ERR<=1 (sticky until RST), LD_DATA_OUT<=0, RF_WE_OUT held 0, OUT_VALID<=1, go to IDLE.
  - ACK arriving on the abort edge wins and completes normally.
- Outside ACCESS: D_MEM_REQ=0 and D_MEM_WE=0. D_MEM_ACK in IDLE is ignored.
- IN_VALID and FLUSH are ignored during ACCESS: the access is committed, and upstream is stalled so it holds its instruction.
- MEM_RD=MEM_WR=1: treated as a store. Load data is not captured; RF_WE_OUT is forced 0.
- Counter width: clog2(WAIT_LIMIT+1), minimum 1. The counter never wraps because abort occurs first.
- Back-to-back memory ops: each op returns to IDLE for one edge before the next is accepted. No overlap of requests.

Test Plan:
1. ALU pass-through: IN_VALID=1, ALU_RESULT=0x00001234, WA=5, RF_WE=1, MEM_RD=MEM_WR=0 -> after one falling edge OUT_VALID=1, ALU_RESULT_OUT=0x00001234, WA_OUT=5, RF_WE_OUT=1; STALL and D_MEM_REQ never 1.
2. Load, ACK on 3rd ACCESS edge: ALU_RESULT=0x00000104, MEM_RD=1, D_MEM_DI=0xDEADBEEF -> D_MEM_REQ=1 and STALL=1 for 3 cycles, D_MEM_ADDR=0x104, D_MEM_WE=0; then LD_DATA_OUT=0xDEADBEEF, OUT_VALID=1, STALL=0.
3. Store, immediate ACK: ST_DATA=0xA5A55A5A, BE=4'b0011, MEM_WR=1, RF_WE=0 -> one ACCESS cycle with D_MEM_WE=1, D_MEM_BE=0011, D_MEM_DOUT=0xA5A55A5A; then OUT_VALID=1, RF_WE_OUT=0.
4. Timeout, WAIT_LIMIT=4, ACK held 0 on a load with RF_WE=1 -> D_MEM_REQ high exactly 4 cycles, then MEM_ERR=1, OUT_VALID=1, RF_WE_OUT=0, LD_DATA_OUT=0; MEM_ERR stays 1 through following instructions until RST.
5. Flush: IN_VALID=1, FLUSH=1 in IDLE -> OUT_VALID=0, RF_WE_OUT=0. FLUSH pulsed during a load ACCESS -> no effect; load completes on ACK.
6. Reset mid-ACCESS: assert RST between falling edges on cycle 2 of a load -> D_MEM_REQ, STALL, OUT_VALID and MEM_ERR are 0 before the next edge; after release a pass-through instruction completes normally.
